// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences power-up locking and dynamic reconfiguration of a hard PLL.
// Latches a new divider/duty/phase set, pulses pll_rst, waits for a stable synchronised
// lock and retries on timeout.
// Optional feature macro: PLL_AUTO_RELOCK_EN -- when defined, loss of lock while idle
// re-runs the reset/lock sequence with the current settings.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DEF_IDIV     = 2,
  parameter int unsigned DEF_FDIV     = 32,
  parameter int unsigned DEF_ODIV     = 100,
  parameter int unsigned DEF_DUTY     = 100,
  parameter int unsigned DEF_PHASE    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [9:0]  cfg_idiv,
  input  logic [9:0]  cfg_fdiv,
  input  logic [9:0]  cfg_odiv0,
  input  logic [9:0]  cfg_odiv1,
  input  logic [9:0]  cfg_duty0,
  input  logic [9:0]  cfg_duty1,
  input  logic [12:0] cfg_phase0,
  input  logic [12:0] cfg_phase1,
  output logic [9:0]  dyn_idiv,
  output logic [9:0]  dyn_fdiv,
  output logic [9:0]  dyn_odiv0,
  output logic [9:0]  dyn_odiv1,
  output logic [9:0]  dyn_duty0,
  output logic [9:0]  dyn_duty1,
  output logic [12:0] dyn_phase0,
  output logic [12:0] dyn_phase1,
  output logic        pll_rst,
  input  logic        pll_lock,
  output logic        locked,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        lock_lost
);

  localparam int unsigned DW  = 10;
  localparam int unsigned PW  = 13;
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TW  = ($clog2(LOCK_TIMEOUT) > 17) ? $clog2(LOCK_TIMEOUT) : 17;
  localparam int unsigned SCW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SCW-1:0] STAB_LAST = SCW'(LOCK_STABLE - 1);
  localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRY);

  typedef struct packed {
    logic [DW-1:0] idiv;
    logic [DW-1:0] fdiv;
    logic [DW-1:0] odiv0;
    logic [DW-1:0] odiv1;
    logic [DW-1:0] duty0;
    logic [DW-1:0] duty1;
    logic [PW-1:0] phase0;
    logic [PW-1:0] phase1;
  } pll_cfg_t;

  localparam pll_cfg_t DEF_CFG = '{
    idiv:   DW'(DEF_IDIV),
    fdiv:   DW'(DEF_FDIV),
    odiv0:  DW'(DEF_ODIV),
    odiv1:  DW'(DEF_ODIV),
    duty0:  DW'(DEF_DUTY),
    duty1:  DW'(DEF_DUTY),
    phase0: PW'(DEF_PHASE),
    phase1: PW'(DEF_PHASE)
  };

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_RST_HOLD  = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_STABLE    = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t         state;
  pll_cfg_t       cap_cfg;
  pll_cfg_t       dyn_cfg;
  pll_cfg_t       cfg_in_c;
  logic           lock_meta;
  logic           lock_s;
  logic [RCW-1:0] rst_cnt;
  logic [TW-1:0]  wait_cnt;
  logic [SCW-1:0] stab_cnt;
  logic [2:0]     retry_cnt;
  logic           accept_c;
  logic           cap_bad_c;

  assign cfg_in_c = '{
    idiv:   cfg_idiv,
    fdiv:   cfg_fdiv,
    odiv0:  cfg_odiv0,
    odiv1:  cfg_odiv1,
    duty0:  cfg_duty0,
    duty1:  cfg_duty1,
    phase0: cfg_phase0,
    phase1: cfg_phase1
  };

  // A transfer happens only while the controller advertises ready (IDLE or ERROR).
  assign accept_c  = cfg_valid & cfg_ready;

  // Any zero divider would stall the PLL, so such a set is rejected outright.
  assign cap_bad_c = (cap_cfg.idiv  == '0) || (cap_cfg.fdiv  == '0) ||
                     (cap_cfg.odiv0 == '0) || (cap_cfg.odiv1 == '0);

  assign dyn_idiv   = dyn_cfg.idiv;
  assign dyn_fdiv   = dyn_cfg.fdiv;
  assign dyn_odiv0  = dyn_cfg.odiv0;
  assign dyn_odiv1  = dyn_cfg.odiv1;
  assign dyn_duty0  = dyn_cfg.duty0;
  assign dyn_duty1  = dyn_cfg.duty1;
  assign dyn_phase0 = dyn_cfg.phase0;
  assign dyn_phase1 = dyn_cfg.phase1;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Reconfiguration sequencer with registered outputs; reset starts the power-up sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST_HOLD;
      cap_cfg   <= DEF_CFG;
      dyn_cfg   <= DEF_CFG;
      pll_rst   <= 1'b1;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
      busy      <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      lock_lost <= 1'b0;
      rst_cnt   <= '0;
      wait_cnt  <= '0;
      stab_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          locked <= lock_s;
          if (accept_c) begin
            cap_cfg   <= cfg_in_c;
            lock_lost <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end else if (locked && !lock_s) begin
            lock_lost <= 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
            retry_cnt <= '0;
            rst_cnt   <= '0;
            pll_rst   <= 1'b1;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_RST_HOLD;
`endif
          end
        end

        S_ERROR: begin
          locked  <= 1'b0;
          pll_rst <= 1'b0;
          if (accept_c) begin
            cap_cfg   <= cfg_in_c;
            lock_lost <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cap_bad_c) begin
            cfg_err   <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            dyn_cfg   <= cap_cfg;
            retry_cnt <= '0;
            rst_cnt   <= '0;
            pll_rst   <= 1'b1;
            locked    <= 1'b0;
            state     <= S_RST_HOLD;
          end
        end

        S_RST_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            pll_rst  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (wait_cnt < TO_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (lock_s) begin
            stab_cnt <= '0;
            state    <= S_STABLE;
          end else if (wait_cnt >= TO_LAST) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              rst_cnt   <= '0;
              pll_rst   <= 1'b1;
              state     <= S_RST_HOLD;
            end else begin
              cfg_err   <= 1'b1;
              cfg_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_ERROR;
            end
          end
        end

        S_STABLE: begin
          // The timeout budget keeps running so a chattering lock cannot extend it.
          if (wait_cnt < TO_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
          end else if (stab_cnt == STAB_LAST) begin
            cfg_done  <= 1'b1;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end

        default: begin
          rst_cnt <= '0;
          pll_rst <= 1'b1;
          busy    <= 1'b1;
          state   <= S_RST_HOLD;
        end
      endcase
    end
  end

endmodule
